// File: rtl/match_logger_if.sv
// Record stream from the match logger to the host-side reader.
// Ports: OUT_VLD/OUT_POS/OUT_STATE driven by the logger (master), OUT_READY by the reader (slave).
// Plain valid/ready: a record moves on every cycle where OUT_VLD and OUT_READY are both high.
interface match_logger_if #(
  parameter int POS_W   = 16,
  parameter int STATE_W = 8
);
  logic               OUT_VLD;
  logic               OUT_READY;
  logic [POS_W-1:0]   OUT_POS;
  logic [STATE_W-1:0] OUT_STATE;

  modport master (
    output OUT_VLD,
    output OUT_POS,
    output OUT_STATE,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VLD,
    input  OUT_POS,
    input  OUT_STATE,
    output OUT_READY
  );
endinterface

// File: rtl/match_logger.sv
// sync_fifo: generic first-word-fall-through FIFO with an explicit occupancy count.
// Latency: a write is visible at rd_dat/rd_vld one cycle later; a pop advances the head at the next edge.
// Backpressure: wr_rdy drops when full unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clr          synchronous clear; writes and pops in the clear cycle are ignored
//   wr_vld/_rdy  write handshake, wr_dat is the entry to append
//   rd_vld/_rdy  head handshake, rd_dat is the head entry (garbage while rd_vld=0)
//   level        number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic                   wr_rdy,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             do_wr;
  logic             do_rd;

  assign rd_vld = (level_q != '0);
  assign do_rd  = rd_vld && rd_rdy && !clr;
  // A pop in the same cycle frees the slot being written, so a full FIFO
  // still takes the write.
  assign wr_rdy = (level_q != FULL_LVL) || do_rd;
  assign do_wr  = wr_vld && wr_rdy && !clr;

  // Pointers wrap naturally at DEPTH (power of two); occupancy is counted
  // separately so full and empty stay distinguishable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  assign rd_dat = mem[rd_ptr];
  assign level  = level_q;
endmodule

// match_logger: logs {position, state} for every match from the Aho-Corasick stage.
// Latency: a match accepted in cycle N is at the head (OUT_VLD=1) from cycle N+1.
// Backpressure: OUT_READY low fills the FIFO; matches that find it full are dropped and set OVF.
//
// Ports:
//   CLK, RST    clock and synchronous active-high reset (priority over everything)
//   CLR         synchronous clear of position, FIFO, match counter and overflow flag
//   CHAR_EN     one pulse per character consumed; advances the position counter
//   MATCH_VLD   strobe qualifying MATCH and STATE_DATA
//   MATCH       match flag; an event is MATCH_VLD && MATCH
//   STATE_DATA  automaton state logged with the match
//   out_if      record stream to the reader (OUT_VLD/OUT_READY/OUT_POS/OUT_STATE)
//   MATCH_CNT   saturating count of all match events, dropped ones included
//   LEVEL       FIFO occupancy; FULL when LEVEL == DEPTH
//   OVF         sticky: at least one record was dropped
module match_logger #(
  parameter int DEPTH   = 16,
  parameter int POS_W   = 16,
  parameter int STATE_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CLR,
  input  logic                   CHAR_EN,
  input  logic                   MATCH_VLD,
  input  logic                   MATCH,
  input  logic [STATE_W-1:0]     STATE_DATA,
  match_logger_if.master         out_if,
  output logic [15:0]            MATCH_CNT,
  output logic [$clog2(DEPTH):0] LEVEL,
  output logic                   FULL,
  output logic                   OVF
);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [POS_W-1:0]   pos;
    logic [STATE_W-1:0] state;
  } rec_t;

  logic [POS_W-1:0] pos_q;
  logic [15:0]      cnt_q;
  logic             ovf_q;
  logic             match_ev;
  logic             fifo_wr_rdy;
  logic             fifo_rd_vld;
  rec_t             wr_rec;
  rec_t             head_rec;

  assign match_ev = MATCH_VLD && MATCH;

  // The record takes the position before any same-cycle CHAR_EN increment,
  // i.e. the registered value.
  assign wr_rec = '{pos: pos_q, state: STATE_DATA};

  sync_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (CLK),
    .rst    (RST),
    .clr    (CLR),
    .wr_vld (match_ev),
    .wr_dat (wr_rec),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (out_if.OUT_READY),
    .rd_dat (head_rec),
    .level  (LEVEL)
  );

  // fifo_wr_rdy sees OUT_READY combinationally, but it only reaches the
  // outside world through ovf_q, so OUT_READY has no path to any output.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      pos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (CHAR_EN) pos_q <= pos_q + POS_W'(1);
      if (match_ev && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
      if (match_ev && !fifo_wr_rdy) ovf_q <= 1'b1;
    end
  end

  // Head fields are forced to zero while empty so the unreset storage never
  // shows through after reset.
  assign out_if.OUT_VLD   = fifo_rd_vld;
  assign out_if.OUT_POS   = fifo_rd_vld ? head_rec.pos   : '0;
  assign out_if.OUT_STATE = fifo_rd_vld ? head_rec.state : '0;

  assign MATCH_CNT = cnt_q;
  assign FULL      = (LEVEL == LW'(DEPTH));
  assign OVF       = ovf_q;
endmodule
